cp0_regfile: RTL and testbench

- Coprocessor-0 register bank for the multi-cycle MIPS core.
- Sits at the receiving end of the CP0 write-address/data path from the control unit and provides the MFC0 read port.
- Sequences exception entry itself, writing Status, Cause and EPC on successive cycles, and restores Status on ERET.
- Supplies EPC and the exception vector to the PC mux.

---
 rtl/cp0_pkg.sv | 20 ++
 rtl/cp0_exc_seq.sv | 58 +++++
 rtl/cp0_regfile.sv | 151 +++++++++++++++
 tb/tb_cp0_regfile.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared constants for the CP0 register bank: register numbers, ExcCodes
// and the exception-entry sequencer state encoding.
package cp0_pkg;

    localparam logic [4:0] CP0_ADDR_COUNT   = 5'd9;
    localparam logic [4:0] CP0_ADDR_COMPARE = 5'd11;
    localparam logic [4:0] CP0_ADDR_STATUS  = 5'd12;
    localparam logic [4:0] CP0_ADDR_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_ADDR_EPC     = 5'd14;

    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_BREAK   = 5'd9;
    localparam logic [4:0] EXC_TEQ     = 5'd13;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STATUS = 2'd1;
    localparam logic [1:0] S_CAUSE  = 2'd2;
    localparam logic [1:0] S_EPC    = 2'd3;

endpackage

// File: rtl/cp0_exc_seq.sv
// Exception-entry sequencer: latches the ExcCode/PC of an accepted request
// and steps through the Status, Cause and EPC updates on successive cycles.
module cp0_exc_seq
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        exc_req,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_pc,
    output logic        busy,
    output logic        done,
    output logic        status_we,
    output logic        cause_we,
    output logic        epc_we,
    output logic [4:0]  code_q,
    output logic [31:0] pc_q
);

    logic [1:0] state;

    // State walk plus the code/PC capture; requests only start from idle
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            code_q <= 5'd0;
            pc_q   <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (exc_req) begin
                        code_q <= exc_code;
                        pc_q   <= exc_pc;
                        state  <= S_STATUS;
                    end
                end
                S_STATUS: state <= S_CAUSE;
                S_CAUSE:  state <= S_EPC;
                default:  state <= S_IDLE;
            endcase
        end
    end

    // Completion pulse is registered so it appears in the cycle after the EPC write
    always_ff @(posedge clk) begin
        if (rst) begin
            done <= 1'b0;
        end else begin
            done <= (state == S_EPC);
        end
    end

    assign busy      = (state != S_IDLE);
    assign status_we = (state == S_STATUS);
    assign cause_we  = (state == S_CAUSE);
    assign epc_we    = (state == S_EPC);

endmodule

// File: rtl/cp0_regfile.sv
// CP0 register bank (Status/Cause/EPC) with MTC0 write port, MFC0 read
// port, exception entry sequencing and ERET Status restore.
// Optional Count/Compare timer is enabled by defining CP0_COUNT_COMPARE_EN.
module cp0_regfile
    import cp0_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = 32'h0040_0004,
    parameter int          STATUS_SHIFT = 5
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CP0_W_EN,
    input  logic [4:0]  CP0_W_ADDR,
    input  logic [31:0] CP0_W_DATA,
    input  logic [4:0]  CP0_R_ADDR,
    output logic [31:0] CP0_R_DATA,
    input  logic        EXC_REQ,
    input  logic [4:0]  EXC_CODE,
    input  logic [31:0] EXC_PC,
    input  logic        ERET,
    output logic        EXC_BUSY,
    output logic        EXC_DONE,
    output logic [31:0] EXC_TARGET,
    output logic [31:0] EPC_OUT,
    output logic [31:0] STATUS_OUT
`ifdef CP0_COUNT_COMPARE_EN
    ,
    output logic        TIMER_IRQ
`endif
);

    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic        busy;
    logic        status_we;
    logic        cause_we;
    logic        epc_we;
    logic [4:0]  code_q;
    logic [31:0] pc_q;
    logic        idle_ok;
    logic        wr_ok;

    cp0_exc_seq u_seq (
        .clk       (CLK),
        .rst       (RST),
        .exc_req   (EXC_REQ),
        .exc_code  (EXC_CODE),
        .exc_pc    (EXC_PC),
        .busy      (busy),
        .done      (EXC_DONE),
        .status_we (status_we),
        .cause_we  (cause_we),
        .epc_we    (epc_we),
        .code_q    (code_q),
        .pc_q      (pc_q)
    );

    // A new exception in idle takes priority over ERET and MTC0, and nothing
    // from the core is accepted while the entry sequence runs.
    assign idle_ok = !busy && !EXC_REQ;
    assign wr_ok   = idle_ok && CP0_W_EN;

    // Status: sequencer shift, then ERET restore, then MTC0
    always_ff @(posedge CLK) begin
        if (RST) begin
            status <= 32'd0;
        end else if (status_we) begin
            status <= status << STATUS_SHIFT;
        end else if (idle_ok && ERET) begin
            status <= status >> STATUS_SHIFT;
        end else if (wr_ok && CP0_W_ADDR == CP0_ADDR_STATUS) begin
            status <= CP0_W_DATA;
        end
    end

    // Cause: sequencer only touches the ExcCode field
    always_ff @(posedge CLK) begin
        if (RST) begin
            cause <= 32'd0;
        end else if (cause_we) begin
            cause[6:2] <= code_q;
        end else if (wr_ok && CP0_W_ADDR == CP0_ADDR_CAUSE) begin
            cause <= CP0_W_DATA;
        end
    end

    // EPC: faulting PC from the sequencer, otherwise MTC0
    always_ff @(posedge CLK) begin
        if (RST) begin
            epc <= 32'd0;
        end else if (epc_we) begin
            epc <= pc_q;
        end else if (wr_ok && CP0_W_ADDR == CP0_ADDR_EPC) begin
            epc <= CP0_W_DATA;
        end
    end

`ifdef CP0_COUNT_COMPARE_EN
    logic [31:0] count;
    logic [31:0] compare;
    logic        timer_irq;

    // Count free-runs with wrap; an accepted MTC0 replaces that cycle's increment
    always_ff @(posedge CLK) begin
        if (RST) begin
            count <= 32'd0;
        end else if (wr_ok && CP0_W_ADDR == CP0_ADDR_COUNT) begin
            count <= CP0_W_DATA;
        end else begin
            count <= count + 32'd1;
        end
    end

    // Compare register and sticky timer interrupt, acknowledged by writing Compare
    always_ff @(posedge CLK) begin
        if (RST) begin
            compare   <= 32'd0;
            timer_irq <= 1'b0;
        end else if (wr_ok && CP0_W_ADDR == CP0_ADDR_COMPARE) begin
            compare   <= CP0_W_DATA;
            timer_irq <= 1'b0;
        end else if (count == compare && status[0]) begin
            timer_irq <= 1'b1;
        end
    end

    assign TIMER_IRQ = timer_irq;
`endif

    // MFC0 read mux; unimplemented numbers read as zero
    always_comb begin
        CP0_R_DATA = 32'd0;
        case (CP0_R_ADDR)
            CP0_ADDR_STATUS:  CP0_R_DATA = status;
            CP0_ADDR_CAUSE:   CP0_R_DATA = cause;
            CP0_ADDR_EPC:     CP0_R_DATA = epc;
`ifdef CP0_COUNT_COMPARE_EN
            CP0_ADDR_COUNT:   CP0_R_DATA = count;
            CP0_ADDR_COMPARE: CP0_R_DATA = compare;
`endif
            default:          CP0_R_DATA = 32'd0;
        endcase
    end

    assign EXC_BUSY   = busy;
    assign EXC_TARGET = EXC_VECTOR;
    assign EPC_OUT    = epc;
    assign STATUS_OUT = status;

endmodule

// File: tb/tb_cp0_regfile.sv
// Bench for cp0_regfile: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
// Define CP0_COUNT_COMPARE_EN to also cover the Count/Compare timer.
module tb_cp0_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        w_en;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic [4:0]  r_addr;
    logic [31:0] r_data;
    logic        exc_req;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        eret;
    logic        exc_busy;
    logic        exc_done;
    logic [31:0] exc_target;
    logic [31:0] epc_out;
    logic [31:0] status_out;
`ifdef CP0_COUNT_COMPARE_EN
    logic        timer_irq;
`endif

    int total_cnt = 0;
    int bad_cnt   = 0;

    // Model state: architectural registers plus a count of pending entry steps
    logic [31:0] m_status, m_cause, m_epc, m_pc;
    logic [4:0]  m_code;
    int          m_left;
    logic        m_done;
    bit          m_valid = 1'b0;
    logic [31:0] m_count, m_compare;
    logic        m_irq;

    always #5 clk = ~clk;

    cp0_regfile dut (
        .CLK        (clk),
        .RST        (rst),
        .CP0_W_EN   (w_en),
        .CP0_W_ADDR (w_addr),
        .CP0_W_DATA (w_data),
        .CP0_R_ADDR (r_addr),
        .CP0_R_DATA (r_data),
        .EXC_REQ    (exc_req),
        .EXC_CODE   (exc_code),
        .EXC_PC     (exc_pc),
        .ERET       (eret),
        .EXC_BUSY   (exc_busy),
        .EXC_DONE   (exc_done),
        .EXC_TARGET (exc_target),
        .EPC_OUT    (epc_out),
`ifdef CP0_COUNT_COMPARE_EN
        .TIMER_IRQ  (timer_irq),
`endif
        .STATUS_OUT (status_out)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            bad_cnt++;
            $display("[TB] FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic we, input logic [4:0] wa,
                                 input logic [31:0] wd, input logic [4:0] ra,
                                 input logic rq, input logic [4:0] cd,
                                 input logic [31:0] pc, input logic er);
        rst = r; w_en = we; w_addr = wa; w_data = wd; r_addr = ra;
        exc_req = rq; exc_code = cd; exc_pc = pc; eret = er;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        case (a)
            5'd12: return m_status;
            5'd13: return m_cause;
            5'd14: return m_epc;
`ifdef CP0_COUNT_COMPARE_EN
            5'd9:  return m_count;
            5'd11: return m_compare;
`endif
            default: return 32'd0;
        endcase
    endfunction

    // Model update from the rules: exception steps, else request, else ERET/MTC0
    task automatic model_step();
        logic [31:0] old_status, old_count, old_compare;
        logic        accepted_wr;
        logic        new_done;
        old_status  = m_status;
        old_count   = m_count;
        old_compare = m_compare;
        accepted_wr = 1'b0;
        new_done    = 1'b0;
        if (rst) begin
            m_status = 0; m_cause = 0; m_epc = 0; m_left = 0; m_done = 0;
            m_count = 0; m_compare = 0; m_irq = 0; m_code = 0; m_pc = 0;
            m_valid = 1'b1;
        end else begin
            if (m_left > 0) begin
                if (m_left == 3) m_status = m_status << 5;
                else if (m_left == 2) m_cause[6:2] = m_code;
                else begin
                    m_epc = m_pc;
                    new_done = 1'b1;
                end
                m_left--;
            end else if (exc_req) begin
                m_code = exc_code;
                m_pc   = exc_pc;
                m_left = 3;
            end else begin
                if (eret) m_status = m_status >> 5;
                accepted_wr = w_en;
                if (w_en) begin
                    case (w_addr)
                        5'd12: if (!eret) m_status = w_data;
                        5'd13: m_cause = w_data;
                        5'd14: m_epc = w_data;
`ifdef CP0_COUNT_COMPARE_EN
                        5'd11: m_compare = w_data;
`endif
                        default: ;
                    endcase
                end
            end
            m_done = new_done;
`ifdef CP0_COUNT_COMPARE_EN
            if (accepted_wr && w_addr == 5'd11) m_irq = 1'b0;
            else if (old_count == old_compare && old_status[0]) m_irq = 1'b1;
            if (accepted_wr && w_addr == 5'd9) m_count = w_data;
            else m_count = old_count + 32'd1;
`endif
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Per-cycle comparison of every output against the model
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                checkOutput("r_data", r_data, model_read(r_addr));
                checkOutput("exc_busy", {31'd0, exc_busy}, {31'd0, m_left > 0});
                checkOutput("exc_done", {31'd0, exc_done}, {31'd0, m_done});
                checkOutput("status_out", status_out, m_status);
                checkOutput("epc_out", epc_out, m_epc);
                checkOutput("exc_target", exc_target, 32'h0040_0004);
`ifdef CP0_COUNT_COMPARE_EN
                checkOutput("timer_irq", {31'd0, timer_irq}, {31'd0, m_irq});
`endif
            end
        end
    end

    initial begin
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        stepCycle();
        stepCycle();
        applyStimulus(0, 0, 0, 0, 12, 0, 0, 0, 0);
        #1;
        checkOutput("reset_status", status_out, 32'h0);
        checkOutput("reset_busy", {31'd0, exc_busy}, 32'h0);
        checkOutput("reset_done", {31'd0, exc_done}, 32'h0);

        // MTC0 Status, no bypass in the same cycle
        applyStimulus(0, 1, 12, 32'h1F, 12, 0, 0, 0, 0);
        #1;
        checkOutput("same_cycle_read", r_data, 32'h0);
        stepCycle();
        applyStimulus(0, 0, 0, 0, 12, 0, 0, 0, 0);
        #1;
        checkOutput("mfc0_status", r_data, 32'h1F);

        // Exception entry with ERET, a second request and MTC0 in the busy window
        applyStimulus(0, 0, 0, 0, 12, 1, 8, 32'h0040_0100, 0);
        stepCycle();
        applyStimulus(0, 0, 0, 0, 12, 0, 0, 0, 1);
        #1;
        checkOutput("busy_c1", {31'd0, exc_busy}, 32'h1);
        stepCycle();
        applyStimulus(0, 0, 0, 0, 12, 1, 9, 32'hDEAD_0000, 0);
        #1;
        checkOutput("busy_c2", {31'd0, exc_busy}, 32'h1);
        checkOutput("status_shifted", status_out, 32'h3E0);
        stepCycle();
        applyStimulus(0, 1, 14, 32'h1234_5678, 13, 0, 0, 0, 0);
        #1;
        checkOutput("busy_c3", {31'd0, exc_busy}, 32'h1);
        checkOutput("cause_code", r_data, 32'h20);
        stepCycle();
        applyStimulus(0, 0, 0, 0, 14, 0, 0, 0, 0);
        #1;
        checkOutput("done_pulse", {31'd0, exc_done}, 32'h1);
        checkOutput("busy_end", {31'd0, exc_busy}, 32'h0);
        checkOutput("epc_value", r_data, 32'h0040_0100);
        checkOutput("exc_target_lit", exc_target, 32'h0040_0004);
        stepCycle();
        applyStimulus(0, 0, 0, 0, 13, 0, 0, 0, 0);
        #1;
        checkOutput("done_once", {31'd0, exc_done}, 32'h0);
        checkOutput("cause_after", r_data, 32'h20);
        checkOutput("status_after", status_out, 32'h3E0);

        // ERET restores Status
        applyStimulus(0, 0, 0, 0, 12, 0, 0, 0, 1);
        stepCycle();
        applyStimulus(0, 0, 0, 0, 12, 0, 0, 0, 0);
        #1;
        checkOutput("eret_status", status_out, 32'h1F);
        checkOutput("eret_epc", epc_out, 32'h0040_0100);

        // Reset landing in S_CAUSE
        applyStimulus(0, 0, 0, 0, 12, 1, 13, 32'h0000_0500, 0);
        stepCycle();
        applyStimulus(0, 0, 0, 0, 12, 0, 0, 0, 0);
        stepCycle();
        applyStimulus(1, 0, 0, 0, 12, 0, 0, 0, 0);
        stepCycle();
        applyStimulus(0, 0, 0, 0, 13, 0, 0, 0, 0);
        #1;
        checkOutput("rst_mid_status", status_out, 32'h0);
        checkOutput("rst_mid_cause", r_data, 32'h0);
        checkOutput("rst_mid_epc", epc_out, 32'h0);
        checkOutput("rst_mid_busy", {31'd0, exc_busy}, 32'h0);
        stepCycle();
        checkOutput("rst_mid_nodone", {31'd0, exc_done}, 32'h0);

        // Randomized traffic checked by the per-cycle compare process
        for (int i = 0; i < 3000; i++) begin
            logic [4:0] addrs [6];
            logic [4:0] wa, ra;
            logic [4:0] cd;
            addrs = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0};
            wa = addrs[$urandom_range(0, 5)];
            if (wa == 5'd0) wa = 5'($urandom_range(0, 31));
            ra = addrs[$urandom_range(0, 5)];
            if (ra == 5'd0) ra = 5'($urandom_range(0, 31));
            case ($urandom_range(0, 3))
                0: cd = 5'd8;
                1: cd = 5'd9;
                2: cd = 5'd13;
                default: cd = 5'($urandom_range(0, 31));
            endcase
            applyStimulus($urandom_range(0, 59) == 0, $urandom_range(0, 1) == 1, wa,
                          $urandom(), ra, $urandom_range(0, 5) == 0, cd, $urandom(),
                          $urandom_range(0, 5) == 0);
            stepCycle();
        end

`ifdef CP0_COUNT_COMPARE_EN
        begin
            int waited;
            applyStimulus(1, 0, 0, 0, 9, 0, 0, 0, 0);
            stepCycle();
            applyStimulus(0, 1, 12, 32'h1, 9, 0, 0, 0, 0);
            stepCycle();
            applyStimulus(0, 1, 11, 32'h5, 9, 0, 0, 0, 0);
            stepCycle();
            applyStimulus(0, 1, 9, 32'h0, 9, 0, 0, 0, 0);
            stepCycle();
            applyStimulus(0, 0, 0, 0, 9, 0, 0, 0, 0);
            waited = 0;
            while (!timer_irq && waited < 20) begin
                stepCycle();
                waited++;
            end
            checkOutput("timer_irq_rise", {31'd0, timer_irq}, 32'h1);
            checkOutput("timer_irq_latency", waited, 6);
            applyStimulus(0, 1, 11, 32'd100, 9, 0, 0, 0, 0);
            stepCycle();
            applyStimulus(0, 0, 0, 0, 9, 0, 0, 0, 0);
            #1;
            checkOutput("timer_irq_clear", {31'd0, timer_irq}, 32'h0);
        end
`endif

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        stepCycle();
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
